// File: rtl/ks_mp_add_seq_if.sv
// rtl/ks_mp_add_seq_if.sv - operand, adder and result signal bundle for ks_mp_add_seq
interface ks_mp_add_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  in_cin;
  logic                  in_last;
  logic [DATA_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] add_b;
  logic                  add_cin;
  logic [DATA_WIDTH:0]   add_s;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_sum;
  logic                  out_last;
  logic                  out_cout;
  logic                  busy;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_last, add_s, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_last, add_s, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
  );
endinterface

// File: rtl/ks_mp_add_seq.sv
// rtl/ks_mp_add_seq.sv - multi-precision add sequencer chaining carries through a registered adder
module ks_mp_add_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_LAT    = 2
) (
  input  logic            clk,
  input  logic            rst,
  ks_mp_add_seq_if.slave  bus
);
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ADD_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]            r_state;
  logic                  r_first;
  logic                  r_carry;
  logic                  r_last;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_add_a;
  logic [DATA_WIDTH-1:0] r_add_b;
  logic                  r_add_cin;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_sum;
  logic                  r_out_last;
  logic                  r_out_cout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b1;
      r_carry     <= 1'b0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_add_a   <= bus.in_a;
            r_add_b   <= bus.in_b;
            r_add_cin <= r_first ? bus.in_cin : r_carry;
            r_last    <= bus.in_last;
            r_cnt     <= CNT_LOAD;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Operands stay frozen here so the adder output settles on this word.
          if (r_cnt == '0) begin
            r_out_sum   <= bus.add_s[DATA_WIDTH-1:0];
            r_carry     <= bus.add_s[DATA_WIDTH];
            r_out_last  <= r_last;
            r_out_cout  <= r_last & bus.add_s[DATA_WIDTH];
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (r_out_last) begin
              r_first <= 1'b1;
              r_carry <= 1'b0;
            end else begin
              r_first <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_WAIT) || (r_state == S_OUT);
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_cin   = r_add_cin;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_last  = r_out_last;
  assign bus.out_cout  = r_out_cout;
endmodule

// File: tb/tb_ks_mp_add_seq.sv
// tb/tb_ks_mp_add_seq.sv - bench for ks_mp_add_seq against a wide-integer sum reference
module tb_ks_mp_add_seq;
  localparam int DW      = 32;
  localparam int ADD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ks_mp_add_seq_if #(.DATA_WIDTH(DW)) bus ();

  ks_mp_add_seq #(.DATA_WIDTH(DW), .ADD_LAT(ADD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Adder stand-in: one register stage, so S is settled by the sampling edge T0+2.
  logic [DW:0] s_reg;
  always @(posedge clk) s_reg <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + (DW+1)'(bus.add_cin);
  assign bus.add_s = s_reg;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation of nw words; expectations come from a single wide sum.
  task automatic run_op(input int nw, input logic [127:0] a, input logic [127:0] b,
                        input logic cin, input int bp, input bit hold_rdy);
    logic [128:0] full, part, mask;
    logic [31:0]  ew;
    logic         ecin;
    int           k;
    full = {1'b0, a} + {1'b0, b} + 129'(cin);
    for (int i = 0; i < nw; i++) begin
      mask = (129'(1) << (32 * i)) - 129'(1);
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 129'(cin);
      ecin = part[32 * i];
      ew   = full[32 * i +: 32];
      bus.in_valid  = 1'b1;
      bus.in_a      = a[32 * i +: 32];
      bus.in_b      = b[32 * i +: 32];
      bus.in_cin    = (i == 0) ? cin : 1'($urandom);
      bus.in_last   = (i == nw - 1);
      bus.out_ready = hold_rdy;
      k = 0;
      while (!bus.in_ready && k < 50) begin @(posedge clk); #1; k++; end
      check("in_ready_timeout", 64'(k < 50), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      bus.in_cin   = 1'($urandom);
      bus.in_last  = 1'($urandom);
      check("busy_after_accept", 64'(bus.busy), 64'd1);
      check("in_ready_in_wait", 64'(bus.in_ready), 64'd0);
      check("add_cin", 64'(bus.add_cin), 64'(ecin));
      k = 0;
      while (!bus.out_valid && k < 50) begin @(posedge clk); #1; k++; end
      check("latency", 64'(k), 64'(ADD_LAT));
      check("out_sum", 64'(bus.out_sum), 64'(ew));
      check("out_last", 64'(bus.out_last), 64'(i == nw - 1));
      check("out_cout", 64'(bus.out_cout), (i == nw - 1) ? 64'(full[32 * nw]) : 64'd0);
      if (!hold_rdy) begin
        for (int c = 0; c < bp; c++) begin
          bus.in_valid = 1'b1;
          @(posedge clk); #1;
          check("bp_out_valid", 64'(bus.out_valid), 64'd1);
          check("bp_out_sum", 64'(bus.out_sum), 64'(ew));
          check("bp_in_ready", 64'(bus.in_ready), 64'd0);
          check("bp_add_a", 64'(bus.add_a), 64'(a[32 * i +: 32]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("out_valid_cleared", 64'(bus.out_valid), 64'd0);
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);
      check("idle_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_add_a"}, 64'(bus.add_a), 64'd0);
    check({tag, "_add_cin"}, 64'(bus.add_cin), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_sum"}, 64'(bus.out_sum), 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_out_cout"}, 64'(bus.out_cout), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ra, rb;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(1, 128'hFFFFFFFF, 128'h1, 1'b0, 0, 1'b1);
    run_op(2, 128'h00000000_FFFFFFFF, 128'h00000000_00000001, 1'b0, 1, 1'b0);
    run_op(2, 128'h00000001_7FFFFFFF, 128'h00000001_00000000, 1'b1, 0, 1'b0);
    run_op(1, 128'h12345678, 128'h11111111, 1'b0, 5, 1'b0);

    // Reset while waiting on the adder.
    bus.in_valid = 1'b1; bus.in_a = 32'hFFFFFFFF; bus.in_b = 32'h1;
    bus.in_cin = 1'b0; bus.in_last = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(1, 128'h5, 128'h3, 1'b0, 0, 1'b0);

    // Reset while holding a non-last result whose carry-out is 1.
    bus.in_valid = 1'b1; bus.in_a = 32'hFFFFFFFF; bus.in_b = 32'h1;
    bus.in_cin = 1'b0; bus.in_last = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (ADD_LAT) @(posedge clk);
    #1;
    check("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_out");
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(1, 128'h5, 128'h3, 1'b0, 0, 1'b0);

    run_op(4, {4{32'hFFFFFFFF}}, 128'h1, 1'b0, 0, 1'b1);

    for (int t = 0; t < 8; t++) begin
      ra = 128'({$urandom, $urandom});
      rb = 128'({$urandom, $urandom});
      run_op(2, ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
